// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the write-port arbiter
// and its round-robin picker.
package rf_pkg;

    localparam int RF_AW   = 3;
    localparam int RF_DW   = 8;
    localparam int RF_NREG = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr,
// wrapping modulo N. Shared by read- and write-port arbitration.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j[PW-1:0]]) begin
                any              = 1'b1;
                gnt[j[PW-1:0]]   = 1'b1;
                idx              = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; registered
// we/Addr/wData. Define RF_WRITE_ARB_LOCK_EN for the owner-lock feature.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
`ifdef RF_WRITE_ARB_LOCK_EN
    input  logic [NREQ-1:0]  lock,
`endif
    output logic [NREQ-1:0]  gnt,
    output logic             we,
    output logic [AW-1:0]    Addr,
    output logic [DW-1:0]    wData,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

`ifdef RF_WRITE_ARB_LOCK_EN
    logic [PW-1:0]   owner;

    // While locked, only the owner may compete.
    always_comb begin
        elig = req;
        if (state == ARB_LOCKED)
            elig = req & (NREQ'(1) << owner);
    end
`else
    assign elig = req;
`endif

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (elig),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign gnt      = reset_n ? pick_gnt : '0;
    assign ptr_nxt  = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
    assign win_addr = req_addr[int'(pick_idx) * AW +: AW];
    assign win_data = req_data[int'(pick_idx) * DW +: DW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we    <= 1'b0;
            Addr  <= '0;
            wData <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            state <= ARB_IDLE;
`ifdef RF_WRITE_ARB_LOCK_EN
            owner <= '0;
`endif
        end else begin
            we <= pick_any;
            if (pick_any) begin
                Addr  <= win_addr;
                wData <= win_data;
            end
`ifdef RF_WRITE_ARB_LOCK_EN
            unique case (state)
                ARB_LOCKED: begin
                    if (pick_any) begin
                        if (!lock[owner]) begin
                            state <= ARB_ACTIVE;
                            ptr   <= ptr_nxt;
                        end
                    end else if (!lock[owner]) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    busy <= pick_any;
                    if (pick_any) begin
                        ptr <= ptr_nxt;
                        if (lock[pick_idx]) begin
                            state <= ARB_LOCKED;
                            owner <= pick_idx;
                        end else begin
                            state <= ARB_ACTIVE;
                        end
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
            endcase
`else
            busy  <= pick_any;
            state <= pick_any ? ARB_ACTIVE : ARB_IDLE;
            if (pick_any)
                ptr <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (default build, NREQ=4).
// Hand-computed expectations checked with immediate assertions.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        we;
    logic [2:0]  Addr;
    logic [7:0]  wData;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rf [8];

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .NREQ (4),
        .AW   (3),
        .DW   (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .we       (we),
        .Addr     (Addr),
        .wData    (wData),
        .busy     (busy)
    );

    // Downstream register file model
    always @(posedge clk)
        if (we)
            rf[Addr] <= wData;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ea;
        logic [7:0] ed;
        reset_n  = 1'b0;
        req      = 4'hF;
        req_addr = {3'd7, 3'd5, 3'd3, 3'd1};
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        chk("rst_addr", 32'(Addr), 32'h0);
        chk("rst_wdata", 32'(wData), 32'h0);
        chk("rst_gnt_held", 32'(gnt), 32'h0);

        // Release reset: ptr=0 picks req[0]
        reset_n = 1'b1;
        #1;
        chk("first_gnt", 32'(gnt), 32'h1);
        tick();
        chk("first_we", 32'(we), 32'h1);
        chk("first_addr", 32'(Addr), 32'd1);
        chk("first_data", 32'(wData), 32'hD0);
        chk("first_busy", 32'(busy), 32'h1);
        chk("ptr1_gnt", 32'(gnt), 32'h2);
        req = 4'h0;
        #1;
        chk("idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("idle_we", 32'(we), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_addr_hold", 32'(Addr), 32'd1);

        // Single requester 2
        req      = 4'b0100;
        req_addr = {3'd7, 3'd5, 3'd3, 3'd1};
        req_data = {8'hD3, 8'hA5, 8'hD1, 8'hD0};
        #1;
        chk("single_gnt", 32'(gnt), 32'h4);
        tick();
        req = 4'h0;
        chk("single_we", 32'(we), 32'h1);
        chk("single_addr", 32'(Addr), 32'd5);
        chk("single_data", 32'(wData), 32'hA5);
        #1;
        chk("single_gnt_off", 32'(gnt), 32'h0);
        tick();
        chk("single_we_off", 32'(we), 32'h0);
        chk("single_addr_hold", 32'(Addr), 32'd5);
        chk("single_data_hold", 32'(wData), 32'hA5);
        chk("single_busy_off", 32'(busy), 32'h0);

        // Reset pulse away from edge to return ptr to 0
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req      = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            tick();
            ea = 3'(2 * (k % 4) + 1);
            ed = 8'(8'hD0 + (k % 4));
            chk($sformatf("rr_we%0d", k), 32'(we), 32'h1);
            chk($sformatf("rr_addr%0d", k), 32'(Addr), 32'(ea));
            chk($sformatf("rr_data%0d", k), 32'(wData), 32'(ed));
            #1;
        end
        req = 4'h0;
        tick();
        chk("rr_drain_we", 32'(we), 32'h0);

        // Move ptr to 2 via a grant to requester 1
        req = 4'b0010;
        #1;
        chk("pre_gnt", 32'(gnt), 32'h2);
        tick();
        // Same-address collision from 3 and 1, ptr=2
        req      = 4'b1010;
        req_addr = {3'd2, 3'd5, 3'd2, 3'd1};
        req_data = {8'h11, 8'hD2, 8'h22, 8'hD0};
        #1;
        chk("coll_gnt3", 32'(gnt), 32'h8);
        tick();
        chk("coll_w1_addr", 32'(Addr), 32'd2);
        chk("coll_w1_data", 32'(wData), 32'h11);
        chk("coll_gnt1", 32'(gnt), 32'h2);
        tick();
        req = 4'h0;
        chk("coll_w2_addr", 32'(Addr), 32'd2);
        chk("coll_w2_data", 32'(wData), 32'h22);
        tick();
        chk("coll_rf2", 32'(rf[2]), 32'h22);
        chk("coll_we_off", 32'(we), 32'h0);

        // Reset asserted while we=1
        req = 4'b0001;
        #1;
        tick();
        chk("mid_we_before", 32'(we), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_we", 32'(we), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_gnt", 32'(gnt), 32'h0);
        reset_n = 1'b1;
        req     = 4'hF;
        #1;
        chk("mid_ptr0_gnt", 32'(gnt), 32'h1);
        tick();
        chk("mid_after_busy", 32'(busy), 32'h1);
        req = 4'h0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
